// File: rtl/ofm_stream_checker.sv
// OFM stream scoreboard: compares each accepted beat against a synchronous-read golden memory, per lane, within a signed tolerance.
// Latency: accept -> compare -> DONE (done rises 2 cycles after the last beat); ofm_ready is a constant 1 in RUN, so there is no backpressure.
module ofm_stream_checker #(
    parameter int LANES         = 16,
    parameter int ELEM_WIDTH    = 16,
    parameter int TOTAL_ELEMS   = 173056,
    parameter int ADDR_WIDTH    = 20,
    parameter int TOLERANCE     = 0,
    parameter bit STOP_ON_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          ofm_valid,
    output logic                          ofm_ready,
    input  logic [LANES*ELEM_WIDTH-1:0]   ofm_data,
    output logic                          gold_rd_en,
    output logic [ADDR_WIDTH-1:0]         gold_rd_addr,
    input  logic [LANES*ELEM_WIDTH-1:0]   gold_rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ADDR_WIDTH-1:0]         err_count,
    output logic [ADDR_WIDTH-1:0]         first_err_addr
);
    localparam int NUM_BEATS  = (TOTAL_ELEMS + LANES - 1) / LANES;
    localparam int LAST_LANES = TOTAL_ELEMS - (NUM_BEATS - 1) * LANES;
    localparam int CNT_W      = $clog2(LANES + 1);
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(NUM_BEATS - 1);
    localparam logic [ELEM_WIDTH:0]   TOL       = (ELEM_WIDTH + 1)'(TOLERANCE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                        vld;
        logic [ADDR_WIDTH-1:0]       beat;
        logic [LANES*ELEM_WIDTH-1:0] dat;
    } stage_t;

    state_t                state;
    stage_t                s1;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic                  accept;
    logic [LANES-1:0]      lane_err;
    logic [CNT_W-1:0]      err_pop;
    logic [LANE_W-1:0]     first_lane;
    logic                  cmp_err;
    logic [ADDR_WIDTH:0]   err_sum;
    logic [ADDR_WIDTH-1:0] err_next;
    logic [ADDR_WIDTH-1:0] err_addr;

    assign accept       = ofm_valid && ofm_ready;
    assign gold_rd_en   = accept;
    assign gold_rd_addr = beat_cnt;

    // Golden data for s1 arrives this cycle; diff is taken one bit wider so 7FFF vs 8000 cannot wrap to a match.
    always_comb begin
        logic signed [ELEM_WIDTH:0] a;
        logic signed [ELEM_WIDTH:0] g;
        logic signed [ELEM_WIDTH:0] d;
        logic        [ELEM_WIDTH:0] mag;
        a          = '0;
        g          = '0;
        d          = '0;
        mag        = '0;
        lane_err   = '0;
        err_pop    = '0;
        first_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            a   = $signed({s1.dat[k*ELEM_WIDTH + ELEM_WIDTH - 1], s1.dat[k*ELEM_WIDTH +: ELEM_WIDTH]});
            g   = $signed({gold_rd_data[k*ELEM_WIDTH + ELEM_WIDTH - 1], gold_rd_data[k*ELEM_WIDTH +: ELEM_WIDTH]});
            d   = a - g;
            mag = d[ELEM_WIDTH] ? $unsigned(-d) : $unsigned(d);
            if (s1.vld && (s1.beat != LAST_BEAT || k < LAST_LANES)) begin
                lane_err[k] = (mag > TOL);
            end
            err_pop = err_pop + CNT_W'(lane_err[k]);
            if (lane_err[k]) begin
                first_lane = LANE_W'(k);
            end
        end
    end

    assign cmp_err  = |lane_err;
    assign err_sum  = {1'b0, err_count} + (ADDR_WIDTH + 1)'(err_pop);
    assign err_next = err_sum[ADDR_WIDTH] ? ALL_ONES : err_sum[ADDR_WIDTH-1:0];
    assign err_addr = ADDR_WIDTH'(s1.beat * LANES) + ADDR_WIDTH'(first_lane);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ofm_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= ALL_ONES;
            beat_cnt       <= '0;
            s1             <= '0;
        end else begin
            if (s1.vld) begin
                err_count <= err_next;
                if (cmp_err && first_err_addr == ALL_ONES) begin
                    first_err_addr <= err_addr;
                end
            end
            s1.vld  <= accept;
            s1.beat <= beat_cnt;
            s1.dat  <= ofm_data;
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        ofm_ready      <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= ALL_ONES;
                        beat_cnt       <= '0;
                    end
                end
                RUN: begin
                    if (STOP_ON_FIRST && cmp_err) begin
                        // A beat accepted alongside the failing compare is dropped unchecked.
                        state     <= DONE;
                        ofm_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_next == '0);
                        s1.vld    <= 1'b0;
                    end else if (accept && beat_cnt == LAST_BEAT) begin
                        state     <= DRAIN;
                        ofm_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    ofm_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    pass      <= (err_next == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ofm_stream_checker.md
Name: ofm_stream_checker

Overview:
- Synthesizable, self-checking scoreboard for the OFM output stream of the conv/maxpool/upsample datapath.
- Compares every OFM element written back against a golden image held in a separate ROM/DPRAM, beat by beat, with an optional signed tolerance.
- Reports pass/fail, the mismatch count and the first failing element address, so FPGA runs can self-verify without dumping the OFM memory.
- Parametrised in lane count, element width, layer size, tolerance and stop policy; it replaces the per-layer simulation-only compare.

Parameters:
- LANES, 16, elements per beat (matches SYSTOLIC_SIZE).
- ELEM_WIDTH, 16, bits per element (2*DATA_WIDTH), signed.
- TOTAL_ELEMS, 173056, elements to check (OFM_SIZE*OFM_SIZE*NO_FILTER; default 52*52*64).
- ADDR_WIDTH, 20, width of element addresses and counters; must satisfy 2^ADDR_WIDTH > TOTAL_ELEMS.
- TOLERANCE, 0, maximum allowed |rtl - golden| for a match, unsigned.
- STOP_ON_FIRST, 1, 1 = finish at the first mismatching beat; 0 = check all elements and count every mismatch.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse that starts a check run
- ofm_valid  input  1  OFM beat valid
- ofm_ready  output  1  checker accepts a beat
- ofm_data  input  LANES*ELEM_WIDTH  OFM beat; lane k occupies bits [k*ELEM_WIDTH +: ELEM_WIDTH]
- gold_rd_en  output  1  golden memory read enable
- gold_rd_addr  output  ADDR_WIDTH  golden beat index (element address / LANES)
- gold_rd_data  input  LANES*ELEM_WIDTH  golden beat; synchronous read, valid 1 cycle after gold_rd_en
- busy  output  1  high in RUN and DRAIN
- done  output  1  level, high in DONE
- pass  output  1  valid while done; 1 iff err_count == 0
- err_count  output  ADDR_WIDTH  mismatching elements, saturating
- first_err_addr  output  ADDR_WIDTH  element address of the first mismatch; all ones if none

Behaviour:
- Reset: state = IDLE. All outputs 0, except first_err_addr = all ones.
- Beat count: NUM_BEATS = ceil(TOTAL_ELEMS/LANES). In the last beat, only lanes below TOTAL_ELEMS - (NUM_BEATS-1)*LANES are compared; all other lanes are ignored.
- State IDLE:
  - ofm_ready = 0.
  - On start: clear beat_cnt, err_count and first_err_addr (to all ones); go to RUN.
- State RUN:
  - ofm_ready = 1; there is no backpressure.
  - Accept a beat when ofm_valid && ofm_ready. In the same cycle: gold_rd_en = 1, gold_rd_addr = beat_cnt, and ofm_data is registered into the stage-1 register with its beat index.
  - beat_cnt then increments.
  - When the accepted beat is beat NUM_BEATS-1, go to DRAIN.
- Compare stage (one cycle after acceptance):
  - Per lane: diff = sign-extended(rtl) - sign-extended(golden), computed at ELEM_WIDTH+1 bits.
  - The lane mismatches iff |diff| > TOLERANCE.
  - err_count += popcount of mismatching, enabled lanes; it saturates at all ones.
  - first_err_addr is written only while it is still all ones: beat_index*LANES + lowest mismatching lane.
- State DRAIN:
  - ofm_ready = 0.
  - The last beat completes its compare, then go to DONE.
- State DONE:
  - done = 1, busy = 0, ofm_ready = 0.
  - pass, err_count and first_err_addr hold until the next start.
  - start in DONE re-arms: clear as in IDLE, then go to RUN.
- STOP_ON_FIRST = 1:
  - A mismatch in the compare stage sends RUN straight to DONE.
  - Any beat accepted in that same cycle is discarded: it is not compared and not counted.
- Ignored inputs:
  - start while busy is ignored.
  - ofm_valid in IDLE, DRAIN or DONE is never accepted.
- Latency: done rises 2 cycles after the last beat is accepted (accept -> compare -> DONE).
- Reset mid-run: returns to IDLE immediately and discards all results; the next run needs a new start.

Test Plan:
- All match: LANES=16, TOTAL_ELEMS=64, golden equals stream, valid held high -> 4 beats accepted back-to-back; done 2 cycles after beat 3; pass=1, err_count=0, first_err_addr=all ones.
- Single error, STOP_ON_FIRST=1: element 37 differs by 1 -> done after beat 2's compare; err_count=1, first_err_addr=37; beat 3 not accepted or discarded; pass=0.
- Multi-error counting, STOP_ON_FIRST=0: lanes 2 and 9 of beat 0 and lane 15 of beat 3 wrong -> err_count=3, first_err_addr=2, all 4 beats accepted.
- Tolerance: TOLERANCE=1; errors of +1 and -1 pass; an error of -2 counts; signed case 16'h7FFF vs 16'h8000 counts (no wrap false-match).
- Partial last beat: TOTAL_ELEMS=40 -> 3 beats; lanes 8..15 of beat 2 corrupted -> pass=1. Lane 7 of beat 2 corrupted -> first_err_addr=39.
- Control: gaps in ofm_valid stall correctly; start asserted mid-run has no effect; rst_n low mid-run -> IDLE, outputs at reset values; second start after DONE re-checks with cleared counters.
